// File: rtl/key_conditioner.sv
// Purpose: synchronise and debounce the power and five function buttons; derive the
//          power state and stretch accepted key presses for the slow mode FSM.
// Latency: key -> inN after DEBOUNCE_CYCLES+3 clk; inN held exactly HOLD_CYCLES clk.
// Backpressure: none; new key edges are dropped while a key is held or still pressed.
//
// Ports:
//   clk, rst           - single clock, asynchronous active-high reset
//   btn_power          - raw power button (active-high, asynchronous)
//   btn_fn[4:0]        - raw function buttons: [4] menu, [3] level 1, [2] level 2,
//                        [1] hurricane, [0] self-clean
//   enable             - power state level
//   in1..in5           - held key levels for btn_fn[4]..btn_fn[0], at most one high
//   hold_on_now_state  - a function button is pressed but no inN is high
//
// Build option KEYPAD_LONG_POWER_EN: when defined, enable toggles only after the
// debounced power button has been held for LONG_PRESS_CYCLES; when undefined,
// enable toggles on every debounced power press and LONG_PRESS_CYCLES is unused.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 2_000_000,
  parameter int LONG_PRESS_CYCLES = 300_000_000,
  parameter int HOLD_CYCLES       = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_power,
  input  logic [4:0] btn_fn,
  output logic       enable,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       in5,
  output logic       hold_on_now_state
);

  localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_P  = (MAX_DH > LONG_PRESS_CYCLES) ? MAX_DH : LONG_PRESS_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;

  typedef enum logic [1:0] {K_IDLE, K_HOLD, K_WAIT} key_state_t;

  // Bit 5 is the power button, bits 4:0 the function buttons.
  logic [5:0]    sync_a, sync_b;
  logic [5:0]    db, db_q;
  logic [CW-1:0] db_cnt [6];
  logic [5:0]    rise;

  key_state_t    state;
  logic [CW-1:0] hold_cnt;
  logic [4:0]    keys;      // keys[4] drives in1 ... keys[0] drives in5
  logic [4:0]    pick;
  logic          key_busy_nxt;

  // Two-flop synchroniser for all six raw inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {btn_power, btn_fn};
      sync_b <= sync_a;
    end
  end

  // Per-input debounce: the level flips after DEBOUNCE_CYCLES consecutive
  // samples that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
    end else begin
      db_q <= db;
      for (int i = 0; i < 6; i++) begin
        if (sync_b[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = db & ~db_q;

`ifdef KEYPAD_LONG_POWER_EN
  // pw_cnt counts cycles of continuous debounced press and saturates one past
  // LONG_PRESS_CYCLES, so a long hold toggles exactly once until released.
  logic [CW-1:0] pw_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pw_cnt <= '0;
      enable <= 1'b0;
    end else if (!db[5]) begin
      pw_cnt <= '0;
    end else if (pw_cnt <= CW'(LONG_PRESS_CYCLES)) begin
      pw_cnt <= pw_cnt + 1'b1;
      if (pw_cnt == CW'(LONG_PRESS_CYCLES)) enable <= ~enable;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable <= 1'b0;
    end else if (rise[5]) begin
      enable <= ~enable;
    end
  end
`endif

  // Highest-numbered bit wins: btn_fn[4] (in1) has the top priority.
  always_comb begin
    pick = '0;
    for (int i = 0; i < 5; i++) begin
      if (rise[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

  // True when some inN will be high after this edge; lets the freeze flag
  // stay low on the very edge a key is accepted.
  assign key_busy_nxt = enable && (((state == K_IDLE) && (|rise[4:0])) ||
                                   ((state == K_HOLD) && (hold_cnt != '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= K_IDLE;
      keys              <= '0;
      hold_cnt          <= '0;
      hold_on_now_state <= 1'b0;
    end else begin
      hold_on_now_state <= (|db[4:0]) && !key_busy_nxt;
      case (state)
        K_IDLE: begin
          if (enable && (|rise[4:0])) begin
            keys     <= pick;
            hold_cnt <= CW'(HOLD_CYCLES - 1);
            state    <= K_HOLD;
          end
        end
        K_HOLD: begin
          if (!enable || (hold_cnt == '0)) begin
            keys  <= '0;
            state <= K_WAIT;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        K_WAIT: begin
          // A key still held after its pulse must be released before re-arming.
          if (db[4:0] == '0) state <= K_IDLE;
        end
        default: begin
          keys  <= '0;
          state <= K_IDLE;
        end
      endcase
    end
  end

  assign in1 = keys[4];
  assign in2 = keys[3];
  assign in3 = keys[2];
  assign in4 = keys[1];
  assign in5 = keys[0];

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Front-end for the range-hood controller's buttons. It synchronises and debounces the raw power and five function buttons, and generates the `enable` level from the power button. It turns each accepted function press into a single `in1`..`in5` level held long enough for the slow-clocked mode state machine to sample. It sits directly upstream of the mode state machine and drives its `enable`, `in1`..`in5` and `hold_on_now_state` inputs.

## Interface
- `DEBOUNCE_CYCLES`, 2_000_000: consecutive stable `clk` samples needed before a debounced level changes (20 ms at 100 MHz).
- `LONG_PRESS_CYCLES`, 300_000_000: debounced power-button hold length that toggles `enable` (3 s).
- `HOLD_CYCLES`, 100_000_000: cycles an accepted `inN` stays high (1 s; must exceed one consumer-clock period).
- Counter widths are `$clog2` of the largest parameter, plus 1.

Ports:
- `clk` in 1: the single clock; every register is clocked on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_power` in 1: raw power button, active-high, asynchronous to `clk`.
- `btn_fn` in 5: raw function buttons, active-high. Bit 4 is menu, bit 3 is level 1, bit 2 is level 2, bit 1 is hurricane, bit 0 is self-clean.
- `enable` out 1: power state level.
- `in1`, `in2`, `in3`, `in4`, `in5` out 1 each: held key outputs mapped to `btn_fn[4]`..`btn_fn[0]`. At most one is high at a time.
- `hold_on_now_state` out 1: high while any function button is debounced-pressed and no `inN` is high. Tells the consumer to freeze its state during a press.

Reset values: `enable`=0, `in1`..`in5`=0, `hold_on_now_state`=0. All debounced levels are 0, all counters are 0, and the key FSM is in `K_IDLE`.

## Operation
- **Synchroniser:** each of the 6 raw inputs passes through a 2-flop synchroniser.
- **Debounce:** each synchronised input has its own counter.
  - When the input differs from its debounced level, the counter increments.
  - When the input equals its debounced level, the counter clears.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while the input still differs, the debounced level flips and the counter clears.
- **Power:** `enable` toggles once when the debounced power button has been continuously high for `LONG_PRESS_CYCLES`.
  - A further toggle requires a debounced release first; holding the button longer does nothing more.
  - A power press shorter than `LONG_PRESS_CYCLES` has no effect.
- **Key FSM, `K_IDLE`:**
  - On a debounced rising edge of any function button while `enable`=1, drive the matching `inN` high, load the hold counter, and go to `K_HOLD`.
  - Rising edges while `enable`=0 are ignored.
- **Key FSM, `K_HOLD`:**
  - `inN` stays high for exactly `HOLD_CYCLES` cycles. All new edges in this state are dropped.
  - Then `inN` drops and the FSM goes to `K_WAIT`.
- **Key FSM, `K_WAIT`:**
  - Return to `K_IDLE` once all five debounced function levels are 0.
  - A key held through the whole hold period therefore cannot retrigger.
- **Simultaneous edges in the same cycle:** only the highest priority wins, in order `in1` > `in2` > `in3` > `in4` > `in5`. The others are dropped.
- **`enable` falling while in `K_HOLD`:** the active `inN` clears on the next edge and the FSM goes to `K_WAIT`.
- **`enable` rising:** no `inN` is emitted for keys that were already held before power-on. Only new rising edges count.
- **Reset mid-operation:** every output goes low asynchronously, and no event is replayed after `rst` falls.

## Timing
- **Key latency:** a raw rising edge, held stable, makes `inN` rise on the `DEBOUNCE_CYCLES+3`-th `clk` rising edge after it. That is 2 cycles of synchroniser, `DEBOUNCE_CYCLES` of debounce, and 1 of output register.
- **Key pulse width:** `inN` is high for exactly `HOLD_CYCLES` cycles.
- **Power latency:** `enable` toggles `DEBOUNCE_CYCLES+2+LONG_PRESS_CYCLES+1` cycles after the raw edge.
- **Glitch rejection:** a raw glitch shorter than `DEBOUNCE_CYCLES` cycles (after synchronisation) produces no output change.
- **Register boundary:** all outputs are driven directly from flops; no combinational path runs from `btn_*` to any output.

## Configuration
- `KEYPAD_LONG_POWER_EN` defined: power toggles only on a long press, as described above.
- `KEYPAD_LONG_POWER_EN` undefined:
  - `enable` toggles on the debounced rising edge of `btn_power`, one cycle after it.
  - The `LONG_PRESS_CYCLES` counter is not built, and the parameter is ignored.

## Test plan
Parameters: `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=16, `HOLD_CYCLES`=8.
- **Power on:** hold `btn_power` high for 40 cycles -> `enable` rises at cycle 23, with exactly one toggle. Release and repeat -> `enable` falls.
- **Key while powered:** with `enable`=1, `btn_fn`=5'b01000 for 20 cycles -> `in2` high from cycle 7 to cycle 14 (8 cycles) and never again until release and re-press.
- **Glitch rejection:** `btn_fn[4]` pulses high for 3 cycles -> `in1` stays 0 and `hold_on_now_state` stays 0.
- **Simultaneous keys and lockout:** `btn_fn`=5'b00011 rising in one cycle -> only `in4` fires. Press `btn_fn[4]` during that hold -> dropped, `in1` stays 0.
- **Power-off during hold:** drop `enable` while `in3` is high (long power press) -> `in3` low on the next edge. Pressing keys with `enable`=0 -> no `inN` output.
- **Reset mid-hold:** assert `rst` mid-hold -> all outputs 0 immediately, and nothing fires after release while the button remains held.
